// File: rtl/trap_shaper_cfg.sv
// trap_shaper_cfg: runtime-configurable trapezoidal shaper (k/l delays, pole-zero M)
// with a FILL/RUN start-up state and saturation only at the output stage.
module trap_shaper_cfg #(
  parameter int DATA_W = 16,
  parameter int MAX_DEPTH = 64,
  parameter int M_W = 8,
  parameter int K_DEF = 4,
  parameter int L_DEF = 8,
  parameter int M_DEF = 0,
  parameter int SHIFT_DEF = 0,
  localparam int DW = $clog2(MAX_DEPTH) + 1,
  localparam int ACC_W = DATA_W + M_W + 2 * DW + 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [DW-1:0]            cfg_k,
  input  logic [DW-1:0]            cfg_l,
  input  logic [M_W-1:0]           cfg_m,
  input  logic [4:0]               cfg_shift,
  input  logic                     cfg_load,
  output logic                     cfg_err,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_sat,
  output logic                     busy
);
  localparam int AW = $clog2(MAX_DEPTH);
  localparam int XW = DATA_W + 2;
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] LO = ~HI;
  typedef enum logic {FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] k_q, l_q, cnt_q, cnt_d;
  logic [M_W-1:0] m_q;
  logic [4:0] sh_q;
  logic signed [DATA_W-1:0] hist_q [MAX_DEPTH];
  logic signed [XW-1:0] d_q, d_d;
  logic signed [ACC_W-1:0] p_q, md_q, r_q, s_q, de, me, sv;
  logic [3:0] v_q, t_q;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic ov_q, sat_q, err_q, sat_d, cfg_ok, ld_ok, acc;
  assign cfg_ok = cfg_k != '0 && cfg_k <= cfg_l && {1'b0, cfg_k} + {1'b0, cfg_l} <= (DW + 1)'(MAX_DEPTH);
  assign ld_ok = cfg_load && cfg_ok;
  assign acc = in_valid && !cfg_load;
  assign busy = state_q == FILL;
  assign cfg_err = err_q;
  assign out_valid = ov_q;
  assign out_data = out_q;
  assign out_sat = sat_q;
  // hist_q[i] holds x[n-1-i], so x[n-j] lives at index j-1
  always_comb begin
    d_d = XW'(in_data) - XW'(hist_q[AW'(k_q - 1'b1)]) - XW'(hist_q[AW'(l_q - 1'b1)])
        + XW'(hist_q[AW'(k_q + l_q - 1'b1)]);
    de = ACC_W'(d_q);
    me = ACC_W'(m_q);
    sv = s_q >>> sh_q;
    sat_d = sv > HI || sv < LO;
    out_d = sv > HI ? DATA_W'(HI) : sv < LO ? DATA_W'(LO) : DATA_W'(sv);
    cnt_d = ld_ok ? '0 : acc && state_q == FILL ? cnt_q + 1'b1 : cnt_q;
    state_d = ld_ok ? FILL : acc && state_q == FILL && cnt_q + 1'b1 == k_q + l_q ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (!reset || ld_ok) begin
      for (int i = 0; i < MAX_DEPTH; i++) hist_q[i] <= '0;
      d_q <= '0;
      p_q <= '0;
      md_q <= '0;
      r_q <= '0;
      s_q <= '0;
      v_q <= '0;
      t_q <= '0;
      out_q <= '0;
      ov_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      if (acc) begin
        hist_q[0] <= in_data;
        for (int i = 1; i < MAX_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        d_q <= d_d;
      end
      v_q <= {v_q[2:0], acc};
      t_q <= {t_q[2:0], acc && state_q == RUN};
      if (v_q[0]) begin
        p_q <= p_q + de;
        md_q <= de * me;
      end
      if (v_q[1]) r_q <= p_q + md_q;
      if (v_q[2]) s_q <= s_q + r_q;
      if (v_q[3]) out_q <= out_d;
      ov_q <= v_q[3] && t_q[3];
      sat_q <= v_q[3] && t_q[3] && sat_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q <= DW'(K_DEF);
      l_q <= DW'(L_DEF);
      m_q <= M_W'(M_DEF);
      sh_q <= 5'(SHIFT_DEF);
      state_q <= FILL;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (ld_ok) begin
        k_q <= cfg_k;
        l_q <= cfg_l;
        m_q <= cfg_m;
        sh_q <= cfg_shift;
      end
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= cfg_load && !cfg_ok;
    end
  end
endmodule

// File: tb/tb_trap_shaper_cfg.sv
// tb_trap_shaper_cfg: randomized and directed checks of trap_shaper_cfg against a
// closed-form model s(n) = sum_i d(i)*(n-i+1+M) over samples since the last restart.
module tb_trap_shaper_cfg;
  localparam int DATA_W = 16, MAX_DEPTH = 64, M_W = 8, DW = 7;
  localparam int ACC_W = DATA_W + M_W + 2 * DW + 2;
  localparam longint HI = (longint'(1) <<< (DATA_W - 1)) - 1;
  localparam longint LO = -HI - 1;
  logic clk = 0, reset = 0, in_valid = 0, cfg_load = 0;
  logic signed [DATA_W-1:0] in_data = '0;
  logic [DW-1:0] cfg_k = '0, cfg_l = '0;
  logic [M_W-1:0] cfg_m = '0;
  logic [4:0] cfg_shift = '0;
  logic cfg_err, out_valid, out_sat, busy;
  logic signed [DATA_W-1:0] out_data;

  trap_shaper_cfg dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_shift(cfg_shift),
    .cfg_load(cfg_load), .cfg_err(cfg_err), .out_valid(out_valid),
    .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {int c; int d; logic s;} ev_t;
  ev_t exp_q[$], obs_q[$];
  int cyc = 0, n_vec = 0, n_err = 0, errs_seen = 0, errs_exp = 0;
  int mk = 4, ml = 8, mm = 0, msh = 0;
  longint xs[$], ds[$];
  int step_ref[$];

  function automatic longint xat(int j);
    return j >= 1 ? xs[j-1] : 0;
  endfunction

  // a restart discards every output not yet seen on the port
  task automatic restart(input int k, input int l, input int m, input int sh);
    ev_t keep[$];
    mk = k; ml = l; mm = m; msh = sh;
    xs.delete(); ds.delete();
    foreach (exp_q[i]) if (exp_q[i].c < cyc) keep.push_back(exp_q[i]);
    exp_q = keep;
  endtask

  task automatic push_sample(input longint x);
    longint d, s, o;
    int n;
    xs.push_back(x);
    n = xs.size();
    d = x - xat(n - mk) - xat(n - ml) + xat(n - mk - ml);
    ds.push_back(d);
    if (n > mk + ml) begin
      s = 0;
      for (int i = 1; i <= n; i++) s += ds[i-1] * (n - i + 1 + mm);
      s = (s <<< (64 - ACC_W)) >>> (64 - ACC_W);
      s = s >>> msh;
      o = s > HI ? HI : (s < LO ? LO : s);
      exp_q.push_back('{cyc + 4, int'(o), logic'(o != s)});
    end
  endtask

  task automatic step(input bit v, input int x, input bit ld = 0, input int k = 0,
                      input int l = 0, input int m = 0, input int sh = 0, input bit rst = 0);
    in_valid = v; in_data = DATA_W'(x); cfg_load = ld;
    cfg_k = DW'(k); cfg_l = DW'(l); cfg_m = M_W'(m); cfg_shift = 5'(sh); reset = ~rst;
    @(posedge clk); #1; cyc++;
    if (rst) restart(4, 8, 0, 0);
    else if (ld) begin
      if (k >= 1 && k <= l && k + l <= MAX_DEPTH) restart(k, l, m, sh);
      else errs_exp++;
    end else if (v) push_sample(x);
    if (out_valid === 1'b1) obs_q.push_back('{cyc, int'(out_data), out_sat});
    if (cfg_err === 1'b1) errs_seen++;
    reset = 1; cfg_load = 0; in_valid = 0;
  endtask

  task automatic test_reset();
    int c13;
    ev_t g;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || out_data !== '0 || cfg_err !== 1'b0 || out_sat !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: ov=%b busy=%b data=%0d err=%b sat=%b, want 0 1 0 0 0",
               out_valid, busy, out_data, cfg_err, out_sat);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1, 0);
      n_vec++;
      if (busy !== (i < 12)) begin n_err++; $display("FAIL reset_busy[%0d]: got %b want %b", i, busy, i < 12); end
    end
    step(1, 0);
    c13 = cyc + 4;
    repeat (2) step(1, 0);
    repeat (6) step(0, 0);
    n_vec++;
    if (obs_q.size() == 0 || obs_q[0].c != c13 || obs_q[0].d != 0) begin
      n_err++;
      $display("FAIL reset_first_out: got n=%0d c=%0d d=%0d, want c=%0d d=0", obs_q.size(),
               obs_q.size() ? obs_q[0].c : -1, obs_q.size() ? obs_q[0].d : -1, c13);
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL reset count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL reset out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_step();
    int ramp [12] = '{100, 200, 300, 400, 400, 400, 400, 400, 300, 200, 100, 0};
    int prev = 0, g_inc;
    ev_t g;
    step(0, 0, 1, 4, 8, 0, 0);
    repeat (12) step(1, 0);
    repeat (16) step(1, 100);
    repeat (6) step(0, 0);
    // each output step is the trapezoid value r = p for M = 0
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      g_inc = i < obs_q.size() ? obs_q[i].d - prev : -1;
      if (i < obs_q.size()) prev = obs_q[i].d;
      if (g_inc != ramp[i]) begin n_err++; $display("FAIL step_increment[%0d]: got %0d want %0d", i, g_inc, ramp[i]); end
    end
    step_ref.delete();
    foreach (obs_q[i]) step_ref.push_back(obs_q[i].d);
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL step count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL step out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_gapped();
    ev_t g;
    step(0, 0, 1, 4, 8, 0, 0);
    repeat (12) begin step(1, 0); step(0, 0); end
    repeat (16) begin step(1, 100); step(0, 0); end
    repeat (6) step(0, 0);
    n_vec++;
    if (obs_q.size() != step_ref.size()) begin n_err++; $display("FAIL gapped_len: got %0d want %0d", obs_q.size(), step_ref.size()); end
    foreach (step_ref[i]) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i].d != step_ref[i]) begin
        n_err++; $display("FAIL gapped_data[%0d]: got %0d want %0d", i, i < obs_q.size() ? obs_q[i].d : -1, step_ref[i]);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL gapped count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL gapped out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_saturation();
    int pk;
    bit any_sat;
    ev_t g;
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 0, 1, 32, 32, 0, pass ? 6 : 0);
      repeat (64) step(1, 0);
      repeat (70) step(1, 2000);
      repeat (6) step(0, 0);
      pk = -100000; any_sat = 0;
      foreach (obs_q[i]) begin
        if (obs_q[i].d > pk) pk = obs_q[i].d;
        any_sat |= obs_q[i].s;
      end
      n_vec++;
      if (pk != (pass ? 32000 : 32767) || any_sat != !pass) begin
        n_err++; $display("FAIL sat_peak[%0d]: got peak=%0d sat=%b want peak=%0d sat=%b", pass, pk, any_sat, pass ? 32000 : 32767, !pass);
      end
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL sat count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
        if (g !== exp_q[i]) begin n_err++; $display("FAIL sat out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_bad_cfg();
    int e0;
    ev_t g;
    step(0, 0, 1, 4, 8, 0, 0);
    e0 = errs_seen;
    repeat (12) step(1, 0);
    repeat (4) step(1, 100);
    step(0, 0, 1, 9, 8, 0, 0);
    n_vec++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL bad_cfg_pulse: got err=%b busy=%b want 1 0", cfg_err, busy); end
    repeat (4) step(1, 100);
    n_vec++;
    if (cfg_err !== 1'b0) begin n_err++; $display("FAIL bad_cfg_width: got err=%b want 0", cfg_err); end
    step(1, 100, 1, 9, 8, 0, 0);
    repeat (8) step(1, 100);
    repeat (6) step(0, 0);
    n_vec++;
    if (errs_seen - e0 != 2) begin n_err++; $display("FAIL bad_cfg_errs: got %0d want 2", errs_seen - e0); end
    foreach (step_ref[i]) begin
      n_vec++;
      if (i >= obs_q.size() || obs_q[i].d != step_ref[i]) begin
        n_err++; $display("FAIL bad_cfg_data[%0d]: got %0d want %0d", i, i < obs_q.size() ? obs_q[i].d : -1, step_ref[i]);
      end
    end
    n_vec++;
    if (obs_q.size() != exp_q.size() || errs_seen != errs_exp) begin
      n_err++; $display("FAIL bad_cfg count: got %0d/%0d want %0d/%0d", obs_q.size(), errs_seen, exp_q.size(), errs_exp);
    end
    foreach (exp_q[i]) begin
      n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
      if (g !== exp_q[i]) begin n_err++; $display("FAIL bad_cfg out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_mid_pulse();
    int base;
    ev_t g;
    for (int pass = 0; pass < 2; pass++) begin
      step(0, 0, 1, 4, 8, 0, 0);
      repeat (12) step(1, 0);
      repeat (6) step(1, 100);
      if (pass == 0) step(1, 100, 0, 0, 0, 0, 0, 1);
      else step(1, 100, 1, 4, 8, 0, 0);
      n_vec++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pulse_kill[%0d]: got ov=%b busy=%b want 0 1", pass, out_valid, busy); end
      repeat (12) step(1, 0);
      repeat (16) step(1, 100);
      repeat (6) step(0, 0);
      base = obs_q.size() - step_ref.size();
      foreach (step_ref[i]) begin
        n_vec++;
        if (base < 0 || obs_q[base + i].d != step_ref[i]) begin
          n_err++; $display("FAIL mid_pulse_fresh[%0d]: got %0d want %0d", i, base < 0 ? -1 : obs_q[base + i].d, step_ref[i]);
        end
      end
      n_vec++;
      if (obs_q.size() != exp_q.size()) begin n_err++; $display("FAIL mid_pulse count: got %0d want %0d", obs_q.size(), exp_q.size()); end
      foreach (exp_q[i]) begin
        n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
        if (g !== exp_q[i]) begin n_err++; $display("FAIL mid_pulse out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_random();
    int k, l, m, sh, r, x;
    ev_t g;
    for (int round = 0; round < 4; round++) begin
      k = $urandom_range(1, 32);
      l = $urandom_range(k, 64 - k);
      m = $urandom_range(0, 255);
      sh = $urandom_range(0, 20);
      step(0, 0, 1, k, l, m, sh);
      repeat (200) begin
        r = $urandom_range(0, 99);
        x = int'($urandom_range(0, 4000)) - 2000;
        if (r < 3) step(bit'($urandom_range(0, 1)), x, 1, $urandom_range(0, 40), $urandom_range(0, 40), m, sh);
        else step(r < 70, x);
      end
      repeat (6) step(0, 0);
      n_vec++;
      if (obs_q.size() != exp_q.size() || errs_seen != errs_exp) begin
        n_err++; $display("FAIL random[%0d] count: got %0d/%0d want %0d/%0d", round, obs_q.size(), errs_seen, exp_q.size(), errs_exp);
      end
      foreach (exp_q[i]) begin
        n_vec++; g = i < obs_q.size() ? obs_q[i] : '0;
        if (g !== exp_q[i]) begin n_err++; $display("FAIL random[%0d] out[%0d]: got c=%0d d=%0d s=%b want c=%0d d=%0d s=%b", round, i, g.c, g.d, g.s, exp_q[i].c, exp_q[i].d, exp_q[i].s); end
      end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_step();
    test_gapped();
    test_saturation();
    test_bad_cfg();
    test_mid_pulse();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
